sdcard_spi_engine: RTL

//  Memory-mapped SPI master between the AVR external-SRAM bus decode and the SD card pins.

---
 rtl/sdcard_spi_engine_pkg.sv | 41 ++++
 rtl/sdcard_spi_engine_if.sv | 17 +
 rtl/sdcard_crc_bit.sv | 24 ++
 rtl/sdcard_spi_engine.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/sdcard_spi_engine_pkg.sv
// Shared constants for the SD-card SPI engine: register offsets, CTRL bit positions, CRC polynomials, FSM states.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package sdcard_spi_engine_pkg;

    // Register offsets on sram_a
    localparam logic [2:0] REG_DATA   = 3'd0;
    localparam logic [2:0] REG_CTRL   = 3'd1;
    localparam logic [2:0] REG_CLKDIV = 3'd2;
    localparam logic [2:0] REG_CRC_HI = 3'd3;
    localparam logic [2:0] REG_CRC_LO = 3'd4;
    localparam logic [2:0] REG_CRC7   = 3'd5;

    // CTRL bit positions
    localparam int CTRL_CS      = 0;
    localparam int CTRL_AUTO    = 1;
    localparam int CTRL_CRC_SRC = 2;
    localparam int CTRL_CRC_CLR = 6;
    localparam int CTRL_BUSY    = 7;

    localparam logic [6:0]  CRC7_POLY  = 7'h09;
    localparam logic [15:0] CRC16_POLY = 16'h1021;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } spi_state_t;

    // CTRL read value; CRC_CLR is write-only and always reads back 0
    function automatic logic [7:0] ctrl_readback(input logic busy, input logic src,
                                                 input logic auto_en, input logic cs);
        logic [7:0] r;
        r               = 8'h00;
        r[CTRL_BUSY]    = busy;
        r[CTRL_CRC_SRC] = src;
        r[CTRL_AUTO]    = auto_en;
        r[CTRL_CS]      = cs;
        return r;
    endfunction

endpackage

// File: rtl/sdcard_spi_engine_if.sv
// CPU-side external-SRAM register bus of the SD-card SPI engine.
// Latency: read data and wait are combinational in the slave.
// Backpressure: slave raises sram_wait to stall the access; master holds the strobes until it drops.
interface sdcard_spi_engine_if;
    logic [2:0] sram_a;     // register select
    logic [7:0] sram_d_in;  // write data from CPU
    logic [7:0] sram_d_out; // read data to CPU
    logic       sram_cs;    // block selected
    logic       sram_oe;    // read strobe
    logic       sram_we;    // write strobe
    logic       sram_wait;  // stall this access

    modport master (output sram_a, sram_d_in, sram_cs, sram_oe, sram_we,
                    input  sram_d_out, sram_wait);
    modport slave  (input  sram_a, sram_d_in, sram_cs, sram_oe, sram_we,
                    output sram_d_out, sram_wait);
endinterface

// File: rtl/sdcard_crc_bit.sv
// One-bit serial update of CRC7 (command) and CRC16-CCITT (data), MSB-first shift form.
// Latency: combinational.
// Backpressure: none; caller decides when to register the result.
// Ports: crc7_in/crc16_in current state, tx_bit feeds CRC7, crc16_bit feeds CRC16, *_out next state.
module sdcard_crc_bit
    import sdcard_spi_engine_pkg::*;
(
    input  logic [6:0]  crc7_in,
    input  logic [15:0] crc16_in,
    input  logic        tx_bit,
    input  logic        crc16_bit,
    output logic [6:0]  crc7_out,
    output logic [15:0] crc16_out
);

    logic fb7;
    logic fb16;

    assign fb7       = tx_bit ^ crc7_in[6];
    assign fb16      = crc16_bit ^ crc16_in[15];
    assign crc7_out  = {crc7_in[5:0], 1'b0} ^ (fb7 ? CRC7_POLY : 7'h00);
    assign crc16_out = {crc16_in[14:0], 1'b0} ^ (fb16 ? CRC16_POLY : 16'h0000);

endmodule

// File: rtl/sdcard_spi_engine.sv
// Memory-mapped SPI mode-0 master for an SD card with CRC7/CRC16 and AUTO streaming reads.
// Latency: one byte takes 16*(CLKDIV+1) clk from the start cycle to BUSY low.
// Backpressure: DATA accesses while BUSY raise sram_wait (combinational) until the byte completes.
// Ports: clk, nrst (async active-low); bus = register slave; sdcard_sck/mosi/cs_n out, sdcard_miso in (pre-synchronised).
module sdcard_spi_engine
    import sdcard_spi_engine_pkg::*;
#(
    parameter logic [7:0] DIV_RESET = 8'h7F,
    parameter logic [7:0] IDLE_BYTE = 8'hFF
) (
    input  logic                 clk,
    input  logic                 nrst,
    sdcard_spi_engine_if.slave   bus,
    output logic                 sdcard_sck,
    output logic                 sdcard_mosi,
    input  logic                 sdcard_miso,
    output logic                 sdcard_cs_n
);

    spi_state_t  state_q, state_d;
    logic [7:0]  clkdiv_q;
    logic [7:0]  div_cnt_q;
    logic [7:0]  shift_q;
    logic [7:0]  rx_q;
    logic [2:0]  bit_cnt_q;
    logic        ctrl_cs_q, ctrl_auto_q, ctrl_src_q;
    logic        miso_bit_q;
    logic        sck_q, mosi_q;
    logic [6:0]  crc7_q, crc7_nxt;
    logic [15:0] crc16_q, crc16_nxt;

    logic        busy;
    logic        data_sel, rd_acc, wr_acc;
    logic        data_wr, data_rd_auto, start, ctrl_wr, crc_clr;
    logic [7:0]  start_byte;
    logic        half_evt, rise_evt, fall_evt, last_fall;

    // ---------------- bus decode ----------------
    assign busy     = (state_q == ST_SHIFT);
    assign data_sel = (bus.sram_a == REG_DATA);

    // Only DATA accesses stall; everything else completes immediately even mid-byte
    assign bus.sram_wait = bus.sram_cs & (bus.sram_oe | bus.sram_we) & data_sel & busy;

    assign rd_acc = bus.sram_cs & bus.sram_oe & ~bus.sram_wait;
    assign wr_acc = bus.sram_cs & bus.sram_we & ~bus.sram_wait;

    // A simultaneous read+write of DATA is treated as a plain write
    assign data_wr      = wr_acc & data_sel;
    assign data_rd_auto = rd_acc & data_sel & ctrl_auto_q & ~data_wr;
    assign start        = data_wr | data_rd_auto;
    assign start_byte   = data_wr ? bus.sram_d_in : IDLE_BYTE;

    assign ctrl_wr = wr_acc & (bus.sram_a == REG_CTRL);
    assign crc_clr = ctrl_wr & bus.sram_d_in[CTRL_CRC_CLR];

    always_comb begin
        bus.sram_d_out = 8'h00;
        if (bus.sram_cs && bus.sram_oe) begin
            case (bus.sram_a)
                REG_DATA:   bus.sram_d_out = rx_q;
                REG_CTRL:   bus.sram_d_out = ctrl_readback(busy, ctrl_src_q, ctrl_auto_q, ctrl_cs_q);
                REG_CLKDIV: bus.sram_d_out = clkdiv_q;
                REG_CRC_HI: bus.sram_d_out = crc16_q[15:8];
                REG_CRC_LO: bus.sram_d_out = crc16_q[7:0];
                REG_CRC7:   bus.sram_d_out = {crc7_q, 1'b1};
                default:    bus.sram_d_out = 8'h00;
            endcase
        end
    end

    // ---------------- shift FSM ----------------
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Half-period events fire when the divider counter hits zero; sck level says which edge it is
    always_comb begin
        state_d   = state_q;
        half_evt  = 1'b0;
        rise_evt  = 1'b0;
        fall_evt  = 1'b0;
        last_fall = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                half_evt  = (div_cnt_q == 8'h00);
                rise_evt  = half_evt & ~sck_q;
                fall_evt  = half_evt & sck_q;
                last_fall = fall_evt & (bit_cnt_q == 3'd7);
                if (last_fall) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    sdcard_crc_bit u_crc (
        .crc7_in   (crc7_q),
        .crc16_in  (crc16_q),
        .tx_bit    (shift_q[7]),
        .crc16_bit (ctrl_src_q ? sdcard_miso : shift_q[7]),
        .crc7_out  (crc7_nxt),
        .crc16_out (crc16_nxt)
    );

    // ---------------- registers and datapath ----------------
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            clkdiv_q    <= DIV_RESET;
            div_cnt_q   <= 8'h00;
            shift_q     <= 8'h00;
            rx_q        <= 8'h00;
            bit_cnt_q   <= 3'd0;
            ctrl_cs_q   <= 1'b0;
            ctrl_auto_q <= 1'b0;
            ctrl_src_q  <= 1'b0;
            miso_bit_q  <= 1'b0;
            sck_q       <= 1'b0;
            mosi_q      <= 1'b1;
            crc7_q      <= 7'h00;
            crc16_q     <= 16'h0000;
        end else begin
            if (ctrl_wr) begin
                ctrl_cs_q   <= bus.sram_d_in[CTRL_CS];
                ctrl_auto_q <= bus.sram_d_in[CTRL_AUTO];
                ctrl_src_q  <= bus.sram_d_in[CTRL_CRC_SRC];
            end
            if (wr_acc && (bus.sram_a == REG_CLKDIV)) begin
                clkdiv_q <= bus.sram_d_in;
            end

            if (start) begin
                shift_q   <= start_byte;
                mosi_q    <= start_byte[7];
                div_cnt_q <= clkdiv_q;
                bit_cnt_q <= 3'd0;
                sck_q     <= 1'b0;
            end else if (busy) begin
                // Reload reads clkdiv_q live, so a CLKDIV write lands on the next half period
                div_cnt_q <= half_evt ? clkdiv_q : (div_cnt_q - 8'd1);
                if (rise_evt) begin
                    sck_q      <= 1'b1;
                    miso_bit_q <= sdcard_miso;
                end
                if (fall_evt) begin
                    sck_q     <= 1'b0;
                    shift_q   <= {shift_q[6:0], miso_bit_q};
                    bit_cnt_q <= bit_cnt_q + 3'd1;
                    if (last_fall) begin
                        rx_q <= {shift_q[6:0], miso_bit_q};
                    end else begin
                        mosi_q <= shift_q[6];
                    end
                end
            end

            // A clear in the same cycle as a sampling edge discards that bit's update
            if (crc_clr) begin
                crc7_q  <= 7'h00;
                crc16_q <= 16'h0000;
            end else if (rise_evt) begin
                crc7_q  <= crc7_nxt;
                crc16_q <= crc16_nxt;
            end
        end
    end

    assign sdcard_sck  = sck_q;
    assign sdcard_mosi = mosi_q;
    assign sdcard_cs_n = ~ctrl_cs_q;

endmodule
